// File: rtl/cmult_pkg.sv
// Shared widths, result field offsets and FSM encoding for the sequential complex multiplier.
package cmult_pkg;

    localparam int W      = 32;
    localparam int RES_W  = 4*W + 2;
    localparam int RE_LSB = 2*W + 1;
    localparam int IM_MSB = 2*W;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t MUL0 = 3'd1;
    localparam state_t MUL1 = 3'd2;
    localparam state_t MUL2 = 3'd3;
    localparam state_t MUL3 = 3'd4;

endpackage

// File: rtl/cmult_mul32.sv
// Purpose: signed W x W -> 2W full-precision multiplier, shared across all four partial products.
// Latency: purely combinational.
// Backpressure: none; the caller sequences operands.
module cmult_mul32
    import cmult_pkg::*;
(
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/complex_mult_seq.sv
// Purpose: handshaked complex multiplier; one shared multiplier walks ar*br, ai*bi, ar*bi, ai*br.
// Latency: accept edge to out_valid is 4 edges; out_valid and result last exactly one cycle.
// Backpressure: none; in_valid is ignored while busy, and accepted again in the out_valid cycle.
module complex_mult_seq
    import cmult_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2*W-1:0]     operand1,
    input  logic [2*W-1:0]     operand2,
    output logic               busy,
    output logic               out_valid,
    output logic [RES_W-1:0]   result
);

    state_t                 state_q, state_d;
    logic signed [W-1:0]    ar_q, ai_q, br_q, bi_q;
    logic signed [W-1:0]    mul_a, mul_b;
    logic signed [2*W-1:0]  prod;
    logic signed [2*W:0]    prod_x;
    logic signed [2*W:0]    acc_re_q, acc_re_d;
    logic signed [2*W:0]    acc_im_q, acc_im_d;
    logic [RES_W-1:0]       result_q, result_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q;
    logic                   accept;

    assign accept = (state_q == IDLE) && in_valid;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL0: begin mul_a = ar_q; mul_b = br_q; end
            MUL1: begin mul_a = ai_q; mul_b = bi_q; end
            MUL2: begin mul_a = ar_q; mul_b = bi_q; end
            MUL3: begin mul_a = ai_q; mul_b = br_q; end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
    end

    cmult_mul32 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    // Sums need one guard bit; the worst case (-2^(W-1))^2 * 2 exactly fills it.
    assign prod_x = {prod[2*W-1], prod};

    always_comb begin
        state_d     = state_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        result_d    = '0;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: if (in_valid) state_d = MUL0;
            MUL0: begin
                acc_re_d = prod_x;
                state_d  = MUL1;
            end
            MUL1: begin
                acc_re_d = acc_re_q - prod_x;
                state_d  = MUL2;
            end
            MUL2: begin
                acc_im_d = prod_x;
                state_d  = MUL3;
            end
            MUL3: begin
                result_d[RES_W-1:RE_LSB] = acc_re_q;
                result_d[IM_MSB:0]       = acc_im_q + prod_x;
                out_valid_d              = 1'b1;
                state_d                  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (state_d != IDLE);
            if (accept) begin
                ar_q <= operand1[2*W-1:W];
                ai_q <= operand1[W-1:0];
                br_q <= operand2[2*W-1:W];
                bi_q <= operand2[W-1:0];
            end
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_complex_mult_seq.sv
// Randomized and directed scoreboard bench for complex_mult_seq against a plain-arithmetic complex product.
module tb_complex_mult_seq;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [63:0]   operand1, operand2;
    logic          busy, out_valid;
    logic [129:0]  result;

    complex_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operand1  (operand1),
        .operand2  (operand2),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [129:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   last_acc = -1000;

    function automatic logic [129:0] pack(input logic signed [64:0] re, input logic signed [64:0] im);
        return {re, im};
    endfunction

    function automatic logic [129:0] cmul_ref(input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] ar, ai, br, bi, re, im;
        ar = $signed(a[63:32]);
        ai = $signed(a[31:0]);
        br = $signed(b[63:32]);
        bi = $signed(b[31:0]);
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return pack(re, im);
    endfunction

    function automatic logic [31:0] rnd_comp();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7fff_ffff;
            2:       return 32'hffff_ffff;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [63:0] rnd_op();
        return {rnd_comp(), rnd_comp()};
    endfunction

    task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Acceptance rule: only when idle, i.e. at least 5 edges after the previous accept.
    task automatic drive(input logic v, input logic [63:0] o1, input logic [63:0] o2,
                         input logic [129:0] exp);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = v;
        operand1 = o1;
        operand2 = o2;
        if (v && (cyc + 1 >= last_acc + 5)) begin
            last_acc = cyc + 1;
            e.cyc    = cyc + 5;
            e.res    = exp;
            sb_q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rnd_op(), rnd_op(), '0);
    endtask

    task automatic send(input logic [63:0] o1, input logic [63:0] o2);
        drive(1'b1, o1, o2, cmul_ref(o1, o2));
    endtask

    task automatic monitor();
        exp_t e;
        logic busy_exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                busy_exp = (cyc >= last_acc) && (cyc <= last_acc + 3);
                chk("busy", {129'b0, busy}, {129'b0, busy_exp});
                if (out_valid) begin
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_out_valid @cyc %0d: got out_valid=1, want 0", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        if (cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL out_valid_latency: got cyc %0d, want cyc %0d", cyc, e.cyc);
                        end
                        chk("result", result, e.res);
                    end
                end else begin
                    chk("result_zero_when_idle", result, '0);
                    if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL missing_out_valid: got none at cyc %0d, want one at cyc %0d",
                                 cyc, sb_q[0].cyc);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        logic signed [64:0] m, re_e, im_e;
        logic [63:0] o1, o2;
        int target;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        operand1 = '0;
        operand2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {129'b0, out_valid}, '0);
        chk("reset_busy", {129'b0, busy}, '0);
        chk("reset_result", result, '0);
        #1 rst_n = 1'b1;

        fork
            monitor();
        join_none

        // (3+4j)*(1+2j) = -5 + 10j
        drive(1'b1, 64'h00000003_00000004, 64'h00000001_00000002, pack(-65'sd5, 65'sd10));
        idle(6);

        // (-2^31 - 2^31 j)^2 = 0 + 2^63 j
        drive(1'b1, 64'h80000000_80000000, 64'h80000000_80000000,
              pack(65'sd0, 65'sh0_8000_0000_0000_0000));
        idle(6);

        // ((2^31-1) - 2^31 j)^2
        m    = 65'sd2147483647;
        re_e = m * m - (65'sd1 <<< 62);
        im_e = -(m * (65'sd1 <<< 32));
        drive(1'b1, 64'h7fffffff_80000000, 64'h7fffffff_80000000, pack(re_e, im_e));
        idle(6);

        // in_valid held for 10 cycles with changing data
        for (int i = 0; i < 10; i++) send(rnd_op(), rnd_op());
        idle(6);

        // reset while the transaction is in MUL2
        send(rnd_op(), rnd_op());
        repeat (3) @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", {129'b0, out_valid}, '0);
        chk("midrst_busy", {129'b0, busy}, '0);
        chk("midrst_result", result, '0);
        sb_q.delete();
        last_acc = -1000;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(6);

        // (1+1j)*(1-1j) = 2 + 0j
        drive(1'b1, 64'h00000001_00000001, 64'h00000001_ffffffff, pack(65'sd2, 65'sd0));
        idle(6);

        // random, mostly back-to-back traffic
        target = n_acc + 10000;
        while (n_acc < target) begin
            o1 = rnd_op();
            o2 = rnd_op();
            drive($urandom_range(0, 9) != 0, o1, o2, cmul_ref(o1, o2));
        end
        idle(10);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results still outstanding, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
